// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes, FSM state encoding and window addressing helper
// for the parametrised LCD window controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE    = 4'd0;
    localparam logic [3:0] CMD_UP       = 4'd1;
    localparam logic [3:0] CMD_DOWN     = 4'd2;
    localparam logic [3:0] CMD_LEFT     = 4'd3;
    localparam logic [3:0] CMD_RIGHT    = 4'd4;
    localparam logic [3:0] CMD_AVG      = 4'd5;
    localparam logic [3:0] CMD_MIRROR_X = 4'd6;
    localparam logic [3:0] CMD_MIRROR_Y = 4'd7;
    localparam logic [3:0] CMD_MAX      = 4'd8;
    localparam logic [3:0] CMD_MIN      = 4'd9;
    localparam logic [3:0] CMD_ROT_CW   = 4'd10;
    localparam logic [3:0] CMD_ROT_CCW  = 4'd11;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_LOAD_LAST = 3'd1,
        ST_IDLE      = 3'd2,
        ST_EXEC      = 3'd3,
        ST_WRITE     = 3'd4
    } state_e;

    // Linear index of the top-left window pixel; (x, y) name the bottom-right corner.
    function automatic int unsigned win_tl_index(input int unsigned x,
                                                 input int unsigned y,
                                                 input int unsigned img_w);
        return (y - 1) * img_w + (x - 1);
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: average, mirror, max/min and rotate.
// Produces the four new pixels and a write-enable for the buffer.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    cmd_i,
    input  logic [DW-1:0] tl_i,
    input  logic [DW-1:0] tr_i,
    input  logic [DW-1:0] bl_i,
    input  logic [DW-1:0] br_i,
    output logic [DW-1:0] tl_o,
    output logic [DW-1:0] tr_o,
    output logic [DW-1:0] bl_o,
    output logic [DW-1:0] br_o,
    output logic          we_o
);

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [DW+1:0] sum_s;
    logic [DW-1:0] avg_s;
    logic [DW-1:0] max_s;
    logic [DW-1:0] min_s;

    // Reductions over the four window pixels; the sum is two bits wider so it never wraps.
    always_comb begin
        sum_s = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
        avg_s = sum_s[DW+1:2];
        max_s = max2(max2(tl_i, tr_i), max2(bl_i, br_i));
        min_s = min2(min2(tl_i, tr_i), min2(bl_i, br_i));
    end

    // Per-command selection of the new window contents.
    always_comb begin
        tl_o = tl_i;
        tr_o = tr_i;
        bl_o = bl_i;
        br_o = br_i;
        we_o = 1'b0;
        case (cmd_i)
            CMD_AVG: begin
                tl_o = avg_s; tr_o = avg_s; bl_o = avg_s; br_o = avg_s; we_o = 1'b1;
            end
            CMD_MIRROR_X: begin
                tl_o = bl_i; bl_o = tl_i; tr_o = br_i; br_o = tr_i; we_o = 1'b1;
            end
            CMD_MIRROR_Y: begin
                tl_o = tr_i; tr_o = tl_i; bl_o = br_i; br_o = bl_i; we_o = 1'b1;
            end
            CMD_MAX: begin
                tl_o = max_s; tr_o = max_s; bl_o = max_s; br_o = max_s; we_o = 1'b1;
            end
            CMD_MIN: begin
                tl_o = min_s; tr_o = min_s; bl_o = min_s; br_o = min_s; we_o = 1'b1;
            end
            CMD_ROT_CW: begin
                tl_o = bl_i; tr_o = tl_i; br_o = tr_i; bl_o = br_i; we_o = 1'b1;
            end
            CMD_ROT_CCW: begin
                tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i; we_o = 1'b1;
            end
            default: begin
                we_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Image-window controller: loads the image from ROM, runs window commands
// and streams the buffer to the result memory on WRITE.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [AW-1:0] IRB_A,
    output logic [DW-1:0] IRB_D,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    state_e        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          irom_en_q, irom_en_d;
    logic [AW-1:0] irom_a_q, irom_a_d;
    logic          irb_rw_q, irb_rw_d;
    logic [AW-1:0] irb_a_q, irb_a_d;
    logic [DW-1:0] irb_d_q, irb_d_d;

    logic [DW-1:0] mem_q [N];

    logic          load_we_s;
    logic [AW-1:0] load_addr_s;
    logic          win_we_s;
    logic [AW-1:0] tl_s, tr_s, bl_s, br_s;
    logic [DW-1:0] alu_tl_s, alu_tr_s, alu_bl_s, alu_br_s;
    logic          alu_we_s;

    // Window corner addresses derived from the current cursor.
    always_comb begin
        tl_s = AW'(win_tl_index(int'(x_q), int'(y_q), IMG_W));
        tr_s = tl_s + AW'(1);
        bl_s = tl_s + AW'(IMG_W);
        br_s = bl_s + AW'(1);
    end

    lcd_win_alu #(.DW(DW)) u_alu (
        .cmd_i (cmd_q),
        .tl_i  (mem_q[tl_s]),
        .tr_i  (mem_q[tr_s]),
        .bl_i  (mem_q[bl_s]),
        .br_i  (mem_q[br_s]),
        .tl_o  (alu_tl_s),
        .tr_o  (alu_tr_s),
        .bl_o  (alu_bl_s),
        .br_o  (alu_br_s),
        .we_o  (alu_we_s)
    );

    // Next-state logic for the sequencer, cursor and output registers.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        x_d         = x_q;
        y_d         = y_q;
        busy_d      = busy_q;
        done_d      = done_q;
        irom_en_d   = irom_en_q;
        irom_a_d    = irom_a_q;
        irb_rw_d    = irb_rw_q;
        irb_a_d     = irb_a_q;
        irb_d_d     = irb_d_q;
        load_we_s   = 1'b0;
        load_addr_s = irom_a_q - AW'(1);
        win_we_s    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                // ROM data lags the address by one cycle, so store the previous address.
                load_we_s = (irom_a_q != ADDR_ZERO);
                if (irom_a_q == ADDR_LAST) begin
                    state_d = ST_LOAD_LAST;
                end else begin
                    irom_a_d = irom_a_q + AW'(1);
                end
            end
            ST_LOAD_LAST: begin
                load_we_s   = 1'b1;
                load_addr_s = ADDR_LAST;
                irom_en_d   = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd_valid && !busy_q) begin
                    cmd_d  = cmd;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    if (cmd == CMD_WRITE) begin
                        state_d  = ST_WRITE;
                        irb_rw_d = 1'b0;
                        irb_a_d  = ADDR_ZERO;
                        irb_d_d  = mem_q[ADDR_ZERO];
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
                win_we_s = alu_we_s;
                case (cmd_q)
                    CMD_UP: begin
                        if (y_q > YW'(1)) y_d = y_q - YW'(1);
                        else              y_d = y_q;
                    end
                    CMD_DOWN: begin
                        if (y_q < YW'(IMG_H - 1)) y_d = y_q + YW'(1);
                        else                      y_d = y_q;
                    end
                    CMD_LEFT: begin
                        if (x_q > XW'(1)) x_d = x_q - XW'(1);
                        else              x_d = x_q;
                    end
                    CMD_RIGHT: begin
                        if (x_q < XW'(IMG_W - 1)) x_d = x_q + XW'(1);
                        else                      x_d = x_q;
                    end
                    default: begin
                        x_d = x_q;
                    end
                endcase
            end
            ST_WRITE: begin
                if (irb_a_q == ADDR_LAST) begin
                    irb_rw_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    irb_a_d = irb_a_q + AW'(1);
                    irb_d_d = mem_q[irb_a_q + AW'(1)];
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD;
            cmd_q     <= 4'd0;
            x_q       <= XW'(IMG_W / 2);
            y_q       <= YW'(IMG_H / 2);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            irom_en_q <= 1'b0;
            irom_a_q  <= ADDR_ZERO;
            irb_rw_q  <= 1'b1;
            irb_a_q   <= ADDR_ZERO;
            irb_d_q   <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            irom_en_q <= irom_en_d;
            irom_a_q  <= irom_a_d;
            irb_rw_q  <= irb_rw_d;
            irb_a_q   <= irb_a_d;
            irb_d_q   <= irb_d_d;
        end
    end

    // Pixel buffer: ROM load port or the four simultaneous window writes.
    always_ff @(posedge clk) begin
        if (load_we_s) begin
            mem_q[load_addr_s] <= IROM_Q;
        end else if (win_we_s) begin
            mem_q[tl_s] <= alu_tl_s;
            mem_q[tr_s] <= alu_tr_s;
            mem_q[bl_s] <= alu_bl_s;
            mem_q[br_s] <= alu_br_s;
        end
    end

    assign IROM_EN = irom_en_q;
    assign IROM_A  = irom_a_q;
    assign IRB_RW  = irb_rw_q;
    assign IRB_A   = irb_a_q;
    assign IRB_D   = irb_d_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench: an image-level model predicts every output each cycle;
// a second instance covers the 10-bit 16x4 geometry.
module tb_lcd_ctrl_param;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cmd, cmd2;
    logic       cmd_valid, cmd_valid2;
    logic [7:0] rom_q;
    logic       IROM_EN, IRB_RW, busy, done;
    logic [5:0] IROM_A, IRB_A;
    logic [7:0] IRB_D;
    logic       IROM_EN2, IRB_RW2, busy2, done2;
    logic [5:0] IROM_A2, IRB_A2;
    logic [9:0] IRB_D2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int rom [N];
    int img [N];
    int cap [N];
    int mx, my;
    int exp_busy, exp_done, exp_en, exp_ia, exp_rw, exp_a, exp_d;

    always #5 clk = ~clk;

    lcd_ctrl_param dut (
        .clk(clk), .reset_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(rom_q),
        .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IRB_RW(IRB_RW), .IRB_A(IRB_A),
        .IRB_D(IRB_D), .busy(busy), .done(done)
    );

    lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4)) dut2 (
        .clk(clk), .reset_n(rst_n), .cmd(cmd2), .cmd_valid(cmd_valid2), .IROM_Q(10'd1023),
        .IROM_EN(IROM_EN2), .IROM_A(IROM_A2), .IRB_RW(IRB_RW2), .IRB_A(IRB_A2),
        .IRB_D(IRB_D2), .busy(busy2), .done(done2)
    );

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (!IROM_EN) rom_q <= 8'(rom[IROM_A]);
    end

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("irom_en", IROM_EN, exp_en);
            chk("irom_a", IROM_A, exp_ia);
            chk("irb_rw", IRB_RW, exp_rw);
            chk("irb_a", IRB_A, exp_a);
            chk("irb_d", IRB_D, exp_d);
            if (IRB_RW === 1'b0) cap[IRB_A] = IRB_D;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cmd_valid2 = 1'b0;
        rst_n = 1'b0;
        exp_busy = 1; exp_done = 0; exp_en = 0; exp_ia = 0; exp_rw = 1; exp_a = 0; exp_d = 0;
        mx = W / 2; my = H / 2;
        chk_en = 1'b1;
        #1;
        chk("rst_irb_rw_now", IRB_RW, 1);
        tick();
        chk("rst_busy", busy, 1);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            tick();
            exp_ia   = (k < N) ? k : N - 1;
            exp_busy = (k <= N) ? 1 : 0;
            exp_en   = (k == N + 1) ? 1 : 0;
        end
        for (int i = 0; i < N; i++) img[i] = rom[i];
        chk("load_busy_low", busy, 0);
        chk("load_irom_a_end", IROM_A, 63);
        chk("load2_busy_low", busy2, 0);
    endtask

    // Image-level effect of one accepted non-write command.
    task automatic apply_cmd(input int c);
        int tl, tr, bl, br, a, b, p, q, v;
        tl = (my - 1) * W + (mx - 1); tr = tl + 1; bl = tl + W; br = bl + 1;
        a = img[tl]; b = img[tr]; p = img[bl]; q = img[br];
        case (c)
            1: if (my > 1) my--;
            2: if (my < H - 1) my++;
            3: if (mx > 1) mx--;
            4: if (mx < W - 1) mx++;
            5: begin v = (a + b + p + q) / 4; img[tl] = v; img[tr] = v; img[bl] = v; img[br] = v; end
            6: begin img[tl] = p; img[bl] = a; img[tr] = q; img[br] = b; end
            7: begin img[tl] = b; img[tr] = a; img[bl] = q; img[br] = p; end
            8: begin
                v = a; if (b > v) v = b; if (p > v) v = p; if (q > v) v = q;
                img[tl] = v; img[tr] = v; img[bl] = v; img[br] = v;
            end
            9: begin
                v = a; if (b < v) v = b; if (p < v) v = p; if (q < v) v = q;
                img[tl] = v; img[tr] = v; img[bl] = v; img[br] = v;
            end
            10: begin img[tl] = p; img[tr] = a; img[br] = b; img[bl] = q; end
            11: begin img[tl] = b; img[tr] = q; img[br] = p; img[bl] = a; end
            default: ;
        endcase
    endtask

    task automatic run_cmd(input int c, input bit hold);
        cmd = 4'(c); cmd_valid = 1'b1;
        tick();
        exp_busy = 1; exp_done = 0;
        if (!hold) cmd_valid = 1'b0;
        if (c == 0) begin
            for (int i = 0; i < N; i++) cap[i] = -1;
            exp_rw = 0; exp_a = 0; exp_d = img[0];
            for (int k = 1; k < N; k++) begin
                tick();
                exp_a = k; exp_d = img[k];
            end
            tick();
            exp_rw = 1; exp_busy = 0; exp_done = 1;
        end else begin
            tick();
            apply_cmd(c);
            exp_busy = 0;
        end
        cmd_valid = 1'b0;
        cmd = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int c, nw, bad;
        rst_n = 1'b1; cmd = 4'd0; cmd2 = 4'd0; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
        for (int i = 0; i < N; i++) rom[i] = i;
        #2;

        do_reset();
        run_cmd(5, 1'b0);
        run_cmd(0, 1'b0);
        chk("avg_27", cap[27], 31); chk("avg_28", cap[28], 31);
        chk("avg_35", cap[35], 31); chk("avg_36", cap[36], 31);
        chk("avg_untouched_63", cap[63], 63);
        for (int i = 0; i < 5; i++) run_cmd(1, 1'b0);
        run_cmd(5, 1'b0);
        run_cmd(0, 1'b1);
        chk("up_clamp_avg_3", cap[3], 7); chk("up_clamp_avg_12", cap[12], 7);

        do_reset();
        run_cmd(8, 1'b0); run_cmd(0, 1'b0);
        chk("max_27", cap[27], 36); chk("max_35", cap[35], 36);
        do_reset();
        run_cmd(9, 1'b0); run_cmd(0, 1'b0);
        chk("min_36", cap[36], 27);
        do_reset();
        run_cmd(10, 1'b0); run_cmd(0, 1'b0);
        chk("rot_tl", cap[27], 35); chk("rot_tr", cap[28], 27);
        chk("rot_br", cap[36], 28); chk("rot_bl", cap[35], 36);
        for (int i = 0; i < 2; i++) run_cmd(6, 1'b1);
        for (int i = 0; i < 2; i++) run_cmd(7, 1'b1);
        run_cmd(0, 1'b1);
        chk("mirror2_tl", cap[27], 35); chk("mirror2_br", cap[36], 28);

        // Wide-pixel, 16x4 instance with a saturated image.
        cmd2 = 4'd5; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        chk("dut2_avg_busy", busy2, 1);
        tick();
        chk("dut2_avg_free", busy2, 0);
        cmd2 = 4'd0; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        nw = 0; bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (IRB_RW2 === 1'b0) begin
                nw++;
                if (IRB_D2 !== 10'd1023) bad++;
            end
            tick();
        end
        chk("dut2_writes", nw, 64);
        chk("dut2_bad_pixels", bad, 0);
        chk("dut2_done", done2, 1);
        chk("dut2_last_d", IRB_D2, 1023);

        // Reset pulsed in the middle of a write-out.
        cmd = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        exp_busy = 1; exp_done = 0; exp_rw = 0; exp_a = 0; exp_d = img[0];
        for (int k = 1; k < 10; k++) begin
            tick();
            exp_a = k; exp_d = img[k];
        end
        for (int i = 0; i < N; i++) rom[i] = $urandom_range(0, 255);
        do_reset();

        // Randomized command stream against the model.
        for (int n = 0; n < 80; n++) begin
            c = $urandom_range(0, 15);
            if (c == 0 && $urandom_range(0, 5) != 0) c = $urandom_range(1, 11);
            run_cmd(c, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        run_cmd(0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
